// File: rtl/axis_cmd_gen_s2mm_mc.sv
// Multi-channel S2MM command generator. Each channel's capture region is
// split into DataMover S2MM commands of at most MAX_BURST_LEN bytes, issued
// round-robin on one shared 72-bit AXIS command port. A channel runs once
// (one-shot) or wraps to its base every pass (continuous ring).
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   m_axis_tdata/tvalid  registered command; tready accepts it
//   base_addr, cap_size  per-channel region (32 bits per channel)
//   mode_cont            1 = continuous ring, 0 = one-shot (sampled at start)
//   start, stop          level start of an idle channel; stop pulse ends a ring
//   ch_reset             synchronous per-channel soft reset
//   busy, cap_done       channel active / sticky completion
//   pass_pulse, pass_cnt pass-complete pulse and per-channel pass counter
module axis_cmd_gen_s2mm_mc #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned BTT_WIDTH     = 23,
  parameter int unsigned MAX_BURST_LEN = 4096,
  parameter int unsigned PASS_CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [71:0]                  m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  input  logic [N_CH*32-1:0]           base_addr,
  input  logic [N_CH*32-1:0]           cap_size,
  input  logic [N_CH-1:0]              mode_cont,
  input  logic [N_CH-1:0]              start,
  input  logic [N_CH-1:0]              stop,
  input  logic [N_CH-1:0]              ch_reset,
  output logic [N_CH-1:0]              busy,
  output logic [N_CH-1:0]              cap_done,
  output logic [N_CH-1:0]              pass_pulse,
  output logic [N_CH*PASS_CNT_W-1:0]   pass_cnt
);

  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [31:0] MAX_LEN = 32'(MAX_BURST_LEN);

  typedef enum logic [1:0] {CH_IDLE, CH_ACTIVE, CH_DONE} ch_state_t;
  typedef enum logic {ISS_ARB, ISS_HOLD} iss_state_t;

  // Per-channel state
  ch_state_t             ch_state   [N_CH];
  logic [31:0]           base_q     [N_CH];
  logic [31:0]           size_q     [N_CH];
  logic [31:0]           cur_addr   [N_CH];
  logic [31:0]           remaining  [N_CH];
  logic [PASS_CNT_W-1:0] pass_cnt_q [N_CH];
  logic [N_CH-1:0]       mode_q;
  logic [N_CH-1:0]       stop_q;

  // Issuer state
  iss_state_t            iss_state;
  logic [CH_W-1:0]       last_grant;
  logic [CH_W-1:0]       hold_ch;
  logic                  hold_live;   // cleared if the held channel is soft-reset
  logic [31:0]           hold_xfer;
  logic                  hold_eof;

  // Combinational arbitration and command build
  logic [N_CH-1:0]       req;
  logic [N_CH-1:0]       accept_ch;
  logic                  grant_found;
  logic [CH_W-1:0]       grant_idx;
  logic [31:0]           sel_addr;
  logic [31:0]           sel_rem;
  logic [31:0]           sel_xfer;
  logic                  sel_eof;
  logic [71:0]           cmd;
  int unsigned           idx;

  // Requests, per-channel acceptance, and round-robin search from last_grant+1
  always_comb begin
    req         = '0;
    accept_ch   = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < int'(N_CH); i++) begin
      req[i]       = (ch_state[i] == CH_ACTIVE) && !ch_reset[i];
      accept_ch[i] = (iss_state == ISS_HOLD) && m_axis_tready && hold_live &&
                     (hold_ch == CH_W'(i));
    end
    for (int unsigned off = 1; off <= N_CH; off++) begin
      idx = (32'(last_grant) + off) % N_CH;
      if (!grant_found && req[CH_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

  // Command fields for the granted channel
  always_comb begin
    sel_addr              = cur_addr[grant_idx];
    sel_rem               = remaining[grant_idx];
    sel_eof               = (sel_rem <= MAX_LEN);
    sel_xfer              = sel_eof ? sel_rem : MAX_LEN;
    cmd                   = '0;
    cmd[BTT_WIDTH-1:0]    = sel_xfer[BTT_WIDTH-1:0];
    cmd[23]               = 1'b1;
    cmd[30]               = sel_eof;
    cmd[31]               = 1'b1;
    cmd[63:32]            = sel_addr;
    cmd[67:64]            = 4'(grant_idx);
  end

  // Output decode of channel registers
  always_comb begin
    busy     = '0;
    cap_done = '0;
    pass_cnt = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      busy[i]                                  = (ch_state[i] == CH_ACTIVE);
      cap_done[i]                              = (ch_state[i] == CH_DONE);
      pass_cnt[i*PASS_CNT_W +: PASS_CNT_W]     = pass_cnt_q[i];
    end
  end

  // Per-channel state machines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_pulse <= '0;
      mode_q     <= '0;
      stop_q     <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        ch_state[i]   <= CH_IDLE;
        base_q[i]     <= '0;
        size_q[i]     <= '0;
        cur_addr[i]   <= '0;
        remaining[i]  <= '0;
        pass_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        pass_pulse[i] <= 1'b0;
        if (ch_reset[i]) begin
          ch_state[i]   <= CH_IDLE;
          pass_cnt_q[i] <= '0;
          stop_q[i]     <= 1'b0;
        end else begin
          case (ch_state[i])
            CH_IDLE: begin
              if (start[i]) begin
                base_q[i]     <= base_addr[32*i +: 32];
                size_q[i]     <= cap_size[32*i +: 32];
                mode_q[i]     <= mode_cont[i];
                cur_addr[i]   <= base_addr[32*i +: 32];
                remaining[i]  <= cap_size[32*i +: 32];
                pass_cnt_q[i] <= '0;
                stop_q[i]     <= 1'b0;
                ch_state[i]   <= (cap_size[32*i +: 32] == 32'd0) ? CH_DONE : CH_ACTIVE;
              end
            end
            CH_ACTIVE: begin
              if (stop[i] && mode_q[i]) stop_q[i] <= 1'b1;
              if (accept_ch[i]) begin
                if (hold_eof) begin
                  pass_pulse[i] <= 1'b1;
                  pass_cnt_q[i] <= pass_cnt_q[i] + PASS_CNT_W'(1);
                  // A stop arriving on the final acceptance still ends the ring
                  if (!mode_q[i] || stop_q[i] || stop[i]) begin
                    ch_state[i] <= CH_DONE;
                    stop_q[i]   <= 1'b0;
                  end else begin
                    cur_addr[i]  <= base_q[i];
                    remaining[i] <= size_q[i];
                  end
                end else begin
                  cur_addr[i]  <= cur_addr[i] + hold_xfer;
                  remaining[i] <= remaining[i] - hold_xfer;
                end
              end
            end
            CH_DONE: ;
            default: ch_state[i] <= CH_IDLE;
          endcase
        end
      end
    end
  end

  // Shared command issuer: ARB registers one command, HOLD waits for tready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_state     <= ISS_ARB;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      last_grant    <= CH_W'(N_CH - 1);
      hold_ch       <= '0;
      hold_live     <= 1'b0;
      hold_xfer     <= '0;
      hold_eof      <= 1'b0;
    end else begin
      case (iss_state)
        ISS_ARB: begin
          if (grant_found) begin
            m_axis_tdata  <= cmd;
            m_axis_tvalid <= 1'b1;
            hold_ch       <= grant_idx;
            hold_live     <= 1'b1;
            hold_xfer     <= sel_xfer;
            hold_eof      <= sel_eof;
            last_grant    <= grant_idx;
            iss_state     <= ISS_HOLD;
          end
        end
        ISS_HOLD: begin
          // The command stays on the bus even if its channel is soft-reset
          if (ch_reset[hold_ch]) hold_live <= 1'b0;
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            hold_live     <= 1'b0;
            iss_state     <= ISS_ARB;
          end
        end
        default: iss_state <= ISS_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_cmd_gen_s2mm_mc.sv
// Directed bench for axis_cmd_gen_s2mm_mc: expected commands are queued when
// a channel is started and compared against the bus by a negedge monitor.
module tb_axis_cmd_gen_s2mm_mc;

  localparam int unsigned N_CH = 4;
  localparam int unsigned PW   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [71:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic [N_CH*32-1:0] base_addr = '0;
  logic [N_CH*32-1:0] cap_size = '0;
  logic [N_CH-1:0]   mode_cont = '0;
  logic [N_CH-1:0]   start = '0;
  logic [N_CH-1:0]   stop = '0;
  logic [N_CH-1:0]   ch_reset = '0;
  logic [N_CH-1:0]   busy;
  logic [N_CH-1:0]   cap_done;
  logic [N_CH-1:0]   pass_pulse;
  logic [N_CH*PW-1:0] pass_cnt;

  axis_cmd_gen_s2mm_mc #(
    .N_CH(N_CH), .BTT_WIDTH(23), .MAX_BURST_LEN(4096), .PASS_CNT_W(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .base_addr(base_addr), .cap_size(cap_size), .mode_cont(mode_cont),
    .start(start), .stop(stop), .ch_reset(ch_reset),
    .busy(busy), .cap_done(cap_done), .pass_pulse(pass_pulse), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int pulse_cnt [N_CH];
  logic [71:0] exp_q [$];

  function automatic logic [71:0] mk(int ch, logic [31:0] addr, int btt, bit eof);
    return {4'h0, 4'(ch), addr, 1'b1, eof, 6'h0, 1'b1, 23'(btt)};
  endfunction

  function automatic logic [PW-1:0] pc(int ch);
    return pass_cnt[ch*PW +: PW];
  endfunction

  task automatic chk(string tag, logic [71:0] obs, logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Queue the commands of one full pass of a channel
  task automatic push_pass(int ch, logic [31:0] base, int size);
    logic [31:0] a = base;
    int rem = size;
    while (rem > 0) begin
      int x = (rem > 4096) ? 4096 : rem;
      exp_q.push_back(mk(ch, a, x, rem <= 4096));
      a   = a + 32'(x);
      rem = rem - x;
    end
  endtask

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(string tag, int limit);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < limit) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, 72'(n < limit), 72'(1));
  endtask

  task automatic set_ch(int ch, logic [31:0] base, int size, bit cont);
    base_addr[ch*32 +: 32] = base;
    cap_size[ch*32 +: 32]  = 32'(size);
    mode_cont[ch]          = cont;
  endtask

  // Bus monitor: every valid cycle must show the queue head
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_CH); i++)
        if (pass_pulse[i]) pulse_cnt[i]++;
      if (m_axis_tvalid) begin
        checks++;
        if (exp_q.size() == 0) begin
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_cmd: observed=%0h expected=none", m_axis_tdata);
          end
        end else begin
          assert (m_axis_tdata === exp_q[0]) else begin
            errors++;
            $error("FAIL cmd: observed=%0h expected=%0h", m_axis_tdata, exp_q[0]);
          end
          if (m_axis_tready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
          end
        end
      end
    end
  end

  initial begin
    int n;
    int acc0;
    int p1;
    for (int i = 0; i < int'(N_CH); i++) pulse_cnt[i] = 0;

    // Reset values
    step(3);
    chk("rst_tvalid", 72'(m_axis_tvalid), 72'(0));
    chk("rst_tdata", m_axis_tdata, 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(cap_done), 72'(0));
    chk("rst_pcnt", 72'(pass_cnt), 72'(0));
    reset = 1'b0;
    step(2);

    // One-shot, single channel, 10000 bytes
    m_axis_tready = 1'b1;
    set_ch(0, 32'h1000_0000, 10000, 1'b0);
    push_pass(0, 32'h1000_0000, 10000);
    start[0] = 1'b1;
    step(1);
    start[0] = 1'b0;
    chk("os_busy_k", 72'(busy[0]), 72'(1));
    chk("os_tvalid_k", 72'(m_axis_tvalid), 72'(0));
    step(1);
    chk("os_tvalid_k1", 72'(m_axis_tvalid), 72'(1));
    wait_drain("os_drain", 50);
    chk("os_done", 72'(cap_done[0]), 72'(1));
    chk("os_busy", 72'(busy[0]), 72'(0));
    chk("os_pcnt", 72'(pc(0)), 72'(1));
    step(1);
    chk("os_pulses", 72'(pulse_cnt[0]), 72'(1));

    // Backpressure, also the exact-MAX_BURST_LEN boundary
    ch_reset[0] = 1'b1; step(1); ch_reset[0] = 1'b0;
    chk("chrst_done0", 72'(cap_done[0]), 72'(0));
    m_axis_tready = 1'b0;
    acc0 = acc_cnt;
    set_ch(1, 32'h2000_0000, 4096, 1'b0);
    push_pass(1, 32'h2000_0000, 4096);
    start[1] = 1'b1; step(1); start[1] = 1'b0;
    n = 0;
    while (!m_axis_tvalid && n < 10) begin step(1); n++; end
    chk("bp_wait", 72'(n < 10), 72'(1));
    for (int c = 0; c < 20; c++) begin
      chk("bp_tvalid", 72'(m_axis_tvalid), 72'(1));
      step(1);
    end
    chk("bp_noacc", 72'(acc_cnt), 72'(acc0));
    m_axis_tready = 1'b1;
    wait_drain("bp_drain", 20);
    step(2);
    chk("bp_acc", 72'(acc_cnt), 72'(acc0 + 1));
    chk("bp_pcnt", 72'(pc(1)), 72'(1));

    // Round-robin across all channels from a fresh reset
    reset = 1'b1; step(2);
    chk("rst2_done", 72'(cap_done), 72'(0));
    reset = 1'b0; step(1);
    for (int i = 0; i < 4; i++) set_ch(i, 32'h3000_0000 + 32'(i) * 32'h10_0000, 8192, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, 32'h3000_0000 + 32'(i) * 32'h10_0000, 4096, 1'b0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, 32'h3000_1000 + 32'(i) * 32'h10_0000, 4096, 1'b1));
    start = 4'hF; step(1); start = '0;
    wait_drain("rr_drain", 40);
    chk("rr_done", 72'(cap_done), 72'hF);
    chk("rr_busy", 72'(busy), 72'h0);
    for (int i = 0; i < 4; i++) chk("rr_pcnt", 72'(pc(i)), 72'(1));

    // Continuous ring on channel 2, stopped during its third pass
    ch_reset = 4'hF; step(1); ch_reset = '0;
    for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
    set_ch(2, 32'h4000_0000, 4096, 1'b1);
    for (int p = 0; p < 3; p++) push_pass(2, 32'h4000_0000, 4096);
    start[2] = 1'b1; step(1); start[2] = 1'b0;
    n = 0;
    while (pulse_cnt[2] < 2 && n < 100) begin step(1); n++; end
    chk("cont_wait", 72'(n < 100), 72'(1));
    stop[2] = 1'b1; step(1); stop[2] = '0;
    wait_drain("cont_drain", 20);
    step(5);
    chk("cont_pulses", 72'(pulse_cnt[2]), 72'(3));
    chk("cont_pcnt", 72'(pc(2)), 72'(3));
    chk("cont_done", 72'(cap_done[2]), 72'(1));
    chk("cont_busy", 72'(busy[2]), 72'(0));
    chk("cont_quiet", 72'(m_axis_tvalid), 72'(0));

    // Boundaries: zero-size region and a one-byte region
    set_ch(3, 32'h7000_0000, 0, 1'b0);
    start[3] = 1'b1; step(1); start[3] = 1'b0;
    chk("sz0_done", 72'(cap_done[3]), 72'(1));
    chk("sz0_busy", 72'(busy[3]), 72'(0));
    step(3);
    chk("sz0_nocmd", 72'(m_axis_tvalid), 72'(0));
    ch_reset[0] = 1'b1; step(1); ch_reset[0] = 1'b0;
    set_ch(0, 32'h7100_0010, 1, 1'b0);
    push_pass(0, 32'h7100_0010, 1);
    start[0] = 1'b1; step(1); start[0] = 1'b0;
    wait_drain("sz1_drain", 20);
    chk("sz1_done", 72'(cap_done[0]), 72'(1));

    // Soft reset of channel 1 while its command is held
    ch_reset = 4'hF; step(1); ch_reset = '0;
    for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
    m_axis_tready = 1'b0;
    set_ch(1, 32'h5000_0000, 8192, 1'b0);
    set_ch(0, 32'h6000_0000, 4096, 1'b0);
    exp_q.push_back(mk(1, 32'h5000_0000, 4096, 1'b0));
    exp_q.push_back(mk(0, 32'h6000_0000, 4096, 1'b1));
    start[1] = 1'b1; step(1); start[1] = 1'b0;
    n = 0;
    while (!m_axis_tvalid && n < 10) begin step(1); n++; end
    chk("cr_wait", 72'(n < 10), 72'(1));
    start[0] = 1'b1; step(1); start[0] = 1'b0;
    p1 = pulse_cnt[1];
    ch_reset[1] = 1'b1; step(1); ch_reset[1] = 1'b0;
    step(2);
    chk("cr_held", 72'(m_axis_tvalid), 72'(1));
    chk("cr_busy1", 72'(busy[1]), 72'(0));
    chk("cr_busy0", 72'(busy[0]), 72'(1));
    m_axis_tready = 1'b1;
    wait_drain("cr_drain", 20);
    step(3);
    chk("cr_done1", 72'(cap_done[1]), 72'(0));
    chk("cr_pcnt1", 72'(pc(1)), 72'(0));
    chk("cr_pulse1", 72'(pulse_cnt[1]), 72'(p1));
    chk("cr_busy1b", 72'(busy[1]), 72'(0));
    chk("cr_done0", 72'(cap_done[0]), 72'(1));
    chk("cr_pcnt0", 72'(pc(0)), 72'(1));
    chk("cr_quiet", 72'(m_axis_tvalid), 72'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
